// File: rtl/uarttx_pkg.sv
// Shared types and line levels for the UART transmit frame generator.
package uarttx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Unused upper bits are zero-filled, so they never disturb the parity.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        calc_parity = odd ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uarttx_frame_gen_if.sv
// Byte handshake and serial line bundle between a producer and the UART transmitter.
interface uarttx_frame_gen_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_serial;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_serial,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_serial,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uarttx_baud_cnt.sv
// Bit-period counter: wraps every CLKS_PER_BIT enabled clocks and flags the last clock of each bit.
module uarttx_baud_cnt #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int                 CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Bit-period counter register; clear wins so every frame starts on a fresh period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            if (cnt_r == CNT_MAX) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bit_end = enable & (cnt_r == CNT_MAX);

endmodule

// File: rtl/uarttx_frame_gen.sv
// UART transmitter: accepts a byte per handshake and serialises start, data (LSB first),
// optional parity and stop bits, each held CLKS_PER_BIT clocks, on a registered line.
module uarttx_frame_gen
    import uarttx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic               clk,
    input  logic               rst,
    uarttx_frame_gen_if.slave  bus
);

    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e            state_r, state_nxt_s;
    logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
    logic [IDX_W-1:0]     bit_idx_r, bit_idx_nxt_s;
    logic                 parity_r, parity_nxt_s;
    logic                 stop_cnt_r, stop_cnt_nxt_s;
    logic                 serial_r, serial_nxt_s;
    logic                 done_r, done_nxt_s;
    logic                 ready_r;
    logic                 busy_r;
    logic                 hs_s;
    logic                 cnt_en_s;
    logic                 bit_end_s;

    assign hs_s     = bus.tx_valid & ready_r;
    assign cnt_en_s = (state_r != IDLE);

    uarttx_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (hs_s),
        .enable  (cnt_en_s),
        .bit_end (bit_end_s)
    );

    // Frame sequencing: next state, shift data and the next line level.
    always_comb begin
        state_nxt_s    = state_r;
        shift_nxt_s    = shift_r;
        bit_idx_nxt_s  = bit_idx_r;
        parity_nxt_s   = parity_r;
        stop_cnt_nxt_s = stop_cnt_r;
        serial_nxt_s   = serial_r;
        done_nxt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                serial_nxt_s = IDLE_LEVEL;
                if (hs_s) begin
                    shift_nxt_s    = bus.tx_data;
                    parity_nxt_s   = calc_parity(8'(bus.tx_data), (PARITY_ODD != 0));
                    bit_idx_nxt_s  = {IDX_W{1'b0}};
                    stop_cnt_nxt_s = 1'b0;
                    serial_nxt_s   = START_LEVEL;
                    state_nxt_s    = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    serial_nxt_s  = shift_r[0];
                    shift_nxt_s   = {1'b0, shift_r[DATA_BITS-1:1]};
                    bit_idx_nxt_s = {IDX_W{1'b0}};
                    state_nxt_s   = DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && (bit_idx_r == IDX_LAST)) begin
                    if (PARITY_EN != 0) begin
                        serial_nxt_s = parity_r;
                        state_nxt_s  = PARITY;
                    end else begin
                        serial_nxt_s = STOP_LEVEL;
                        state_nxt_s  = STOP;
                    end
                end else if (bit_end_s) begin
                    serial_nxt_s  = shift_r[0];
                    shift_nxt_s   = {1'b0, shift_r[DATA_BITS-1:1]};
                    bit_idx_nxt_s = bit_idx_r + IDX_ONE;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    serial_nxt_s = STOP_LEVEL;
                    state_nxt_s  = STOP;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP: begin
                if (bit_end_s && (stop_cnt_r == STOP_LAST)) begin
                    serial_nxt_s = IDLE_LEVEL;
                    done_nxt_s   = 1'b1;
                    state_nxt_s  = IDLE;
                end else if (bit_end_s) begin
                    stop_cnt_nxt_s = stop_cnt_r + 1'b1;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                serial_nxt_s = IDLE_LEVEL;
                state_nxt_s  = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; ready/busy track the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            shift_r    <= {DATA_BITS{1'b0}};
            bit_idx_r  <= {IDX_W{1'b0}};
            parity_r   <= 1'b0;
            stop_cnt_r <= 1'b0;
            serial_r   <= IDLE_LEVEL;
            done_r     <= 1'b0;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            shift_r    <= shift_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            parity_r   <= parity_nxt_s;
            stop_cnt_r <= stop_cnt_nxt_s;
            serial_r   <= serial_nxt_s;
            done_r     <= done_nxt_s;
            ready_r    <= (state_nxt_s == IDLE);
            busy_r     <= (state_nxt_s != IDLE);
        end
    end

    assign bus.tx_serial = serial_r;
    assign bus.tx_ready  = ready_r;
    assign bus.tx_busy   = busy_r;
    assign bus.tx_done   = done_r;

endmodule

// File: tb/tb_uarttx_frame_gen.sv
// Bench for uarttx_frame_gen: three configurations checked every cycle against a
// frame-position model, plus literal waveform and latency expectations.
module tb_uarttx_frame_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic       vld [3];
    logic [7:0] dat [3];
    logic       ser [3];
    logic       rdy [3];
    logic       bsy [3];
    logic       dn  [3];

    int         pos_m  [3] = '{-1, -1, -1};
    logic [7:0] dm     [3];
    logic       done_m [3] = '{1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uarttx_frame_gen_if #(.DATA_BITS(8)) if0 ();
    uarttx_frame_gen_if #(.DATA_BITS(8)) if1 ();
    uarttx_frame_gen_if #(.DATA_BITS(8)) if2 ();

    uarttx_frame_gen #(.CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    uarttx_frame_gen #(.CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    uarttx_frame_gen #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    assign if0.tx_valid = vld[0];
    assign if1.tx_valid = vld[1];
    assign if2.tx_valid = vld[2];
    assign if0.tx_data  = dat[0];
    assign if1.tx_data  = dat[1];
    assign if2.tx_data  = dat[2];
    assign ser[0] = if0.tx_serial;
    assign ser[1] = if1.tx_serial;
    assign ser[2] = if2.tx_serial;
    assign rdy[0] = if0.tx_ready;
    assign rdy[1] = if1.tx_ready;
    assign rdy[2] = if2.tx_ready;
    assign bsy[0] = if0.tx_busy;
    assign bsy[1] = if1.tx_busy;
    assign bsy[2] = if2.tx_busy;
    assign dn[0]  = if0.tx_done;
    assign dn[1]  = if1.tx_done;
    assign dn[2]  = if2.tx_done;

    function automatic int cpb(input int i);
        return (i == 2) ? 4 : 10;
    endfunction
    function automatic int pen(input int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int pod(input int i);
        return (i == 1) ? 1 : 0;
    endfunction
    function automatic int stb(input int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int flen(input int i);
        return (1 + 8 + pen(i) + stb(i)) * cpb(i);
    endfunction

    // Line level pos clocks into a frame carrying d: which bit slot, then what that slot holds.
    function automatic logic level_at(input logic [7:0] d, input int pos, input int i);
        int b;
        b = pos / cpb(i);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pen(i) != 0 && b == 9) return (pod(i) != 0) ? ~(^d) : (^d);
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: every cycle compare all outputs of all instances, then advance.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic e_ser, e_rdy, e_dn;
            if (rst) begin
                pos_m[i]  = -1;
                done_m[i] = 1'b0;
            end
            e_rdy = (pos_m[i] < 0);
            e_ser = e_rdy ? 1'b1 : level_at(dm[i], pos_m[i], i);
            e_dn  = done_m[i];
            chk($sformatf("serial%0d", i), 32'(ser[i]), 32'(e_ser));
            chk($sformatf("ready%0d", i),  32'(rdy[i]), 32'(e_rdy));
            chk($sformatf("busy%0d", i),   32'(bsy[i]), 32'(!e_rdy));
            chk($sformatf("done%0d", i),   32'(dn[i]),  32'(e_dn));
            done_m[i] = 1'b0;
            if (pos_m[i] >= 0) begin
                pos_m[i]++;
                if (pos_m[i] == flen(i)) begin
                    pos_m[i]  = -1;
                    done_m[i] = 1'b1;
                end
            end
            if (!rst && e_rdy && vld[i]) begin
                pos_m[i] = 0;
                dm[i]    = dat[i];
            end
        end
    end

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic wait_hs(input int i, output int hc);
        hc = -1;
        for (int k = 0; k < 1000 && hc < 0; k++) begin
            @(negedge clk);
            if (rdy[i] === 1'b1 && !rst) hc = cyc;
        end
        if (hc < 0) chk("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input int i, input logic [7:0] d, output int hc);
        @(posedge clk); #2;
        vld[i] = 1'b1;
        dat[i] = d;
        wait_hs(i, hc);
        @(posedge clk); #2;
        vld[i] = 1'b0;
        dat[i] = 8'($urandom);
    endtask

    task automatic wait_done(input int i, input int hc, input int lat, input string nm);
        int got;
        got = -1;
        for (int k = 0; k < 400 && got < 0; k++) begin
            @(negedge clk);
            if (dn[i] === 1'b1) got = cyc - hc;
        end
        chk(nm, 32'(got), 32'(lat));
    endtask

    task automatic chk_frame(input int i, input int hc, input logic [9:0] expv, input string nm);
        for (int b = 0; b < 10; b++) begin
            wait_cyc(hc + 1 + b * cpb(i) + cpb(i) / 2);
            chk($sformatf("%s_bit%0d", nm, b), 32'(ser[i]), 32'(expv[b]));
        end
    endtask

    initial begin
        int hc, h2, cnt;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0;
            dat[i] = 8'h00;
        end
        chk("model_flen0", 32'(flen(0)), 32'd100);
        chk("model_flen1", 32'(flen(1)), 32'd110);
        chk("model_flen2", 32'(flen(2)), 32'd44);
        chk("model_par_01", 32'(level_at(8'h01, 95, 1)), 32'd0);
        chk("model_par_03", 32'(level_at(8'h03, 95, 1)), 32'd1);

        @(negedge clk);
        chk("reset_serial", 32'(ser[0]), 32'd1);
        chk("reset_ready",  32'(rdy[0]), 32'd1);
        chk("reset_busy",   32'(bsy[0]), 32'd0);
        chk("reset_done",   32'(dn[0]),  32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Default configuration, 0xA5.
        send(0, 8'hA5, hc);
        chk_frame(0, hc, 10'b1101001010, "a5");
        wait_done(0, hc, 101, "a5_done_latency");

        // Odd parity: 0x01 gives parity 0, 0x03 gives parity 1.
        send(1, 8'h01, hc);
        wait_cyc(hc + 96);
        chk("parity_01", 32'(ser[1]), 32'd0);
        wait_done(1, hc, 111, "par01_done_latency");
        send(1, 8'h03, hc);
        wait_cyc(hc + 96);
        chk("parity_03", 32'(ser[1]), 32'd1);
        wait_done(1, hc, 111, "par03_done_latency");

        // Back-to-back with tx_valid held high.
        @(posedge clk); #2;
        vld[0] = 1'b1;
        dat[0] = 8'h00;
        wait_hs(0, hc);
        @(posedge clk); #2;
        dat[0] = 8'hFF;
        wait_hs(0, h2);
        chk("b2b_hs_spacing", 32'(h2 - hc), 32'd101);
        chk("b2b_gap_high", 32'(ser[0]), 32'd1);
        @(posedge clk); #2;
        vld[0] = 1'b0;
        @(negedge clk);
        chk("b2b_next_start", 32'(ser[0]), 32'd0);
        wait_done(0, h2, 101, "b2b_done_latency");

        // Input activity while busy must be ignored.
        send(0, 8'h3C, hc);
        wait_cyc(hc + 30);
        @(posedge clk); #2;
        dat[0] = 8'hC3;
        vld[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("busy_ready_low", 32'(rdy[0]), 32'd0);
        end
        @(posedge clk); #2;
        vld[0] = 1'b0;
        wait_done(0, hc, 101, "busy_done_latency");
        cnt = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (ser[0] !== 1'b1) cnt++;
        end
        chk("no_extra_frame", 32'(cnt), 32'd0);

        // Reset during data bit 3.
        send(0, 8'hE7, hc);
        wait_cyc(hc + 43);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_serial", 32'(ser[0]), 32'd1);
        chk("midrst_ready",  32'(rdy[0]), 32'd1);
        chk("midrst_done",   32'(dn[0]),  32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (dn[0] === 1'b1) cnt++;
        end
        chk("midrst_no_done", 32'(cnt), 32'd0);
        send(0, 8'h5A, hc);
        chk_frame(0, hc, 10'b1010110100, "5a");
        wait_done(0, hc, 101, "5a_done_latency");

        // Two stop bits at four clocks per bit.
        send(2, 8'h16, hc);
        wait_cyc(hc + 36);
        chk("stop2_last_data", 32'(ser[2]), 32'd0);
        for (int k = 37; k <= 44; k++) begin
            wait_cyc(hc + k);
            chk($sformatf("stop2_level_%0d", k), 32'(ser[2]), 32'd1);
        end
        wait_done(2, hc, 45, "stop2_done_latency");

        // Random traffic across all three configurations.
        for (int n = 0; n < 30; n++) begin
            send($urandom_range(0, 2), 8'($urandom), hc);
            repeat ($urandom_range(0, 60)) @(posedge clk);
        end
        repeat (300) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
